emg_request_arbiter: RTL and testbench
======================================

Name: emg_request_arbiter

Overview:
- Front end for the traffic light controller's emergency inputs.
- Synchronises and debounces the raw NS and EW emergency request lines, and latches each request as pending.
- When requests conflict, arbitrates fairly and drives at most one of emg_ns/emg_ew at a time.
- Releases a grant once the controller is seen in the matching emergency state, then enforces a cooldown before the next grant.

Parameters:
- DEBOUNCE_TICKS, 16, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates (>=1).
- ACK_TIMEOUT, 1024, maximum cycles a grant is held without acknowledgement (>=2).
- COOLDOWN_TICKS, 64, cycles in COOLDOWN before a new grant may issue (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- raw_emg_ns  in  1  asynchronous NS emergency request (level)
- raw_emg_ew  in  1  asynchronous EW emergency request (level)
- ctrl_state  in  3  controller state_debug; EMG_NS=3'd6, EMG_EW=3'd7
- emg_ns  out  1  registered NS emergency request to controller
- emg_ew  out  1  registered EW emergency request to controller
- pend_ns  out  1  NS request latched, not yet serviced
- pend_ew  out  1  EW request latched, not yet serviced
- busy  out  1  FSM not in IDLE
- timeout_pulse  out  1  one-cycle pulse when a grant expires unacknowledged

Behaviour:
- Reset: every output 0, sync/debounce flops 0, FSM=IDLE, timer=0, last_dir=EW (so NS wins the first tie).
- Sync: two flops per raw input.
- Debounce: a per-input counter runs while the synced value differs from the debounced value and clears when they agree. When the counter reaches DEBOUNCE_TICKS-1 and the values still differ, the debounced value flips at the next edge.
- Pending: a rising edge of a debounced input sets pend_x at the next edge. Total latency is DEBOUNCE_TICKS+3 edges after raw is first sampled high. Falling edges have no effect.
- Pending clears on the cycle the FSM enters SERVICE for that direction. If a set and a clear coincide, set wins.
- Timer: counts cycles in the current state; resets to 0 on every state change.
- IDLE → GRANT when either pend is set:
  - Sole pending direction is chosen.
  - If both are pending, the direction != last_dir is chosen.
  - The matching emg_x goes high at the same edge as GRANT entry.
- GRANT: emg_x held high.
  - ctrl_state == matching EMG code → SERVICE: emg_x=0, clear pend_x, last_dir=x.
  - Else, if timer == ACK_TIMEOUT-1 → COOLDOWN: emg_x=0, timeout_pulse=1 for one cycle, pend_x kept, last_dir unchanged.
  - Ack has priority over timeout in the same cycle.
- SERVICE: outputs low; stays while ctrl_state == the matching EMG code, then → COOLDOWN.
- COOLDOWN: → IDLE when timer == COOLDOWN_TICKS-1.
- Invariant: emg_ns & emg_ew is never 1; both are 0 outside GRANT.
- Requests arriving in any non-IDLE state latch as pending and are served after COOLDOWN.
- A request for the direction currently in SERVICE re-pends and is served again after COOLDOWN if still pending.
- ctrl_state showing the other direction's EMG code during GRANT is not an ack; GRANT continues to timeout.
- rst mid-operation: immediate return to the reset state; pending requests are discarded.
- Counter widths: $clog2(param+1); no wrap is reachable.

Decomposition:
- Shared package traffic_pkg holds the controller state codes (S_NS_GREEN..S_EMG_EW, 3-bit) and the arbiter FSM encoding (IDLE, GRANT, SERVICE, COOLDOWN). Both traffic_controller and this block use it.
- Sub-module emg_debounce (2-flop sync + debounce counter, parameter DEBOUNCE_TICKS), instantiated twice.

Test Plan:
Bench params: DEBOUNCE_TICKS=4, ACK_TIMEOUT=16, COOLDOWN_TICKS=8.
- NS-only press with ack:
  - Stimulus: raw_emg_ns high at edge 0; ctrl_state=6 asserted 3 cycles after emg_ns rises, held 10 cycles, then 3'd2.
  - Response: pend_ns=1 at edge 7; emg_ns=1 at edge 8; emg_ns and pend_ns drop one edge after ack; busy low 8 cycles after ctrl_state leaves 6.
- Glitch rejection:
  - Stimulus: raw_emg_ew pulses high for 3 cycles.
  - Response: pend_ew stays 0; emg_ew stays 0.
- Simultaneous requests:
  - Stimulus: both raw lines rise on the same edge from reset.
  - Response: NS granted first. After the NS SERVICE and COOLDOWN, EW is granted. At no cycle are emg_ns and emg_ew both 1.
- Ack timeout:
  - Stimulus: EW pending; ctrl_state never reaches 7.
  - Response: emg_ew high exactly 16 cycles; timeout_pulse=1 for 1 cycle; pend_ew stays 1; re-grant 8 cycles later.
- Request during SERVICE:
  - Stimulus: new EW press debounced while NS is in SERVICE.
  - Response: pend_ew=1 at debounce edge; emg_ew rises only after COOLDOWN completes.
- Reset mid-GRANT:
  - Stimulus: rst asserted for 1 cycle while emg_ns=1.
  - Response: next edge shows all outputs 0 and busy=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: controller state codes and the emergency
// arbiter FSM encoding.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_NS_RED    = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_EW_RED    = 3'd5,
    S_EMG_NS    = 3'd6,
    S_EMG_EW    = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_SERVICE,
    ARB_COOLDOWN
  } arb_state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } emg_dir_e;

  // True when the controller reports the emergency state for direction dir.
  function automatic logic is_emg_ack(input logic [2:0] ctrl, input emg_dir_e dir);
    return (dir == DIR_NS) ? (ctrl == S_EMG_NS) : (ctrl == S_EMG_EW);
  endfunction

endpackage

// File: rtl/emg_debounce.sv
// Two-flop synchroniser plus debounce counter for one emergency request line;
// emits a registered one-cycle pulse on each debounced rising edge.
module emg_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Edge is taken from the registered level so the pulse lands one edge later.
    rise_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/emg_request_arbiter.sv
// Emergency request front end: debounces NS/EW requests, latches them as
// pending and grants one direction at a time with ack, timeout and cooldown.
module emg_request_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned ACK_TIMEOUT    = 1024,
  parameter int unsigned COOLDOWN_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_emg_ns,
  input  logic       raw_emg_ew,
  input  logic [2:0] ctrl_state,
  output logic       emg_ns,
  output logic       emg_ew,
  output logic       pend_ns,
  output logic       pend_ew,
  output logic       busy,
  output logic       timeout_pulse
);

  localparam int unsigned TMAX = (ACK_TIMEOUT > COOLDOWN_TICKS) ? ACK_TIMEOUT : COOLDOWN_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  arb_state_e    state_q, state_d;
  emg_dir_e      dir_q, dir_d;
  emg_dir_e      last_dir_q, last_dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_ns_q, pend_ns_d;
  logic          pend_ew_q, pend_ew_d;
  logic          emg_ns_q, emg_ns_d;
  logic          emg_ew_q, emg_ew_d;
  logic          timeout_q, timeout_d;
  logic          ns_rise, ew_rise;
  logic          ack;
  logic          clr_ns, clr_ew;

  emg_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_ns (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (raw_emg_ns),
    .rise_o (ns_rise)
  );

  emg_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_ew (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (raw_emg_ew),
    .rise_o (ew_rise)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    timeout_d  = 1'b0;
    clr_ns     = 1'b0;
    clr_ew     = 1'b0;
    ack        = is_emg_ack(ctrl_state, dir_q);

    case (state_q)
      ARB_IDLE: begin
        if (pend_ns_q || pend_ew_q) begin
          state_d = ARB_GRANT;
          if (pend_ns_q && pend_ew_q) begin
            dir_d = (last_dir_q == DIR_NS) ? DIR_EW : DIR_NS;
          end else begin
            dir_d = pend_ns_q ? DIR_NS : DIR_EW;
          end
        end
      end
      ARB_GRANT: begin
        if (ack) begin
          state_d    = ARB_SERVICE;
          last_dir_d = dir_q;
          clr_ns     = (dir_q == DIR_NS);
          clr_ew     = (dir_q == DIR_EW);
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d   = ARB_COOLDOWN;
          timeout_d = 1'b1;
        end
      end
      ARB_SERVICE: begin
        if (!ack) state_d = ARB_COOLDOWN;
      end
      ARB_COOLDOWN: begin
        if (timer_q == TW'(COOLDOWN_TICKS - 1)) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Saturating so a long SERVICE or IDLE dwell cannot wrap into a false match.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == '1) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    pend_ns_d = ns_rise | (pend_ns_q & ~clr_ns);
    pend_ew_d = ew_rise | (pend_ew_q & ~clr_ew);
    emg_ns_d  = (state_d == ARB_GRANT) && (dir_d == DIR_NS);
    emg_ew_d  = (state_d == ARB_GRANT) && (dir_d == DIR_EW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      dir_q      <= DIR_NS;
      last_dir_q <= DIR_EW;
      timer_q    <= '0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      emg_ns_q   <= 1'b0;
      emg_ew_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      timer_q    <= timer_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      emg_ns_q   <= emg_ns_d;
      emg_ew_q   <= emg_ew_d;
      timeout_q  <= timeout_d;
    end
  end

  assign emg_ns        = emg_ns_q;
  assign emg_ew        = emg_ew_q;
  assign pend_ns       = pend_ns_q;
  assign pend_ew       = pend_ew_q;
  assign busy          = (state_q != ARB_IDLE);
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_emg_request_arbiter.sv
// Scoreboard bench for emg_request_arbiter: expected output vectors are queued
// by cycle when stimulus is driven and compared on the falling clock edge.
module tb_emg_request_arbiter;

  localparam int unsigned DB = 4;
  localparam int unsigned AT = 16;
  localparam int unsigned CD = 8;

  // Output vector bit positions: {emg_ns, emg_ew, pend_ns, pend_ew, busy, timeout_pulse}
  localparam logic [5:0] ENS = 6'b100000;
  localparam logic [5:0] EEW = 6'b010000;
  localparam logic [5:0] PNS = 6'b001000;
  localparam logic [5:0] PEW = 6'b000100;
  localparam logic [5:0] BSY = 6'b000010;
  localparam logic [5:0] TMO = 6'b000001;
  localparam logic [5:0] ALL = 6'b111111;
  localparam logic [5:0] NON = 6'b000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_emg_ns, raw_emg_ew;
  logic [2:0] ctrl_state;
  logic       emg_ns, emg_ew, pend_ns, pend_ew, busy, timeout_pulse;
  logic [5:0] obs;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [5:0]  mask;
    logic [5:0]  val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc   = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  emg_request_arbiter #(
    .DEBOUNCE_TICKS(DB),
    .ACK_TIMEOUT   (AT),
    .COOLDOWN_TICKS(CD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_emg_ns   (raw_emg_ns),
    .raw_emg_ew   (raw_emg_ew),
    .ctrl_state   (ctrl_state),
    .emg_ns       (emg_ns),
    .emg_ew       (emg_ew),
    .pend_ns      (pend_ns),
    .pend_ew      (pend_ew),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {emg_ns, emg_ew, pend_ns, pend_ew, busy, timeout_pulse};

  task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b want %b", tag, cyc, got, want);
    end
  endtask

  task automatic expect_at(input int unsigned c, input string tag,
                           input logic [5:0] mask, input logic [5:0] val);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.tag  = tag;
    e.mask = mask;
    e.val  = val;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
    sb_q.insert(i, e);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    check_vec("mutex", {5'b0, emg_ns & emg_ew}, 6'b0);
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check_vec(e.tag, obs & e.mask, e.val & e.mask);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned c, e0, g;
    rst        = 1'b1;
    raw_emg_ns = 1'b0;
    raw_emg_ew = 1'b0;
    ctrl_state = 3'd0;
    wait_cyc(3);
    rst = 1'b0;
    expect_at(cyc, "reset", ALL, NON);

    // NS-only press acknowledged by the controller
    wait_cyc(cyc + 2);
    raw_emg_ns = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6,  "ns_pend_early", PNS | BSY,             NON);
    expect_at(e0 + 7,  "ns_pend_set",   PNS | ENS,             PNS);
    expect_at(e0 + 8,  "ns_grant",      ENS | PNS | BSY,       ENS | PNS | BSY);
    expect_at(e0 + 10, "ns_hold",       ENS | BSY | TMO,       ENS | BSY);
    expect_at(e0 + 11, "ns_ack",        ENS | PNS | BSY,       BSY);
    expect_at(e0 + 20, "ns_service",    ENS | BSY,             BSY);
    expect_at(e0 + 28, "ns_cooldown",   BSY,                   BSY);
    expect_at(e0 + 29, "ns_idle",       ALL,                   NON);
    wait_cyc(e0 + 10); ctrl_state = 3'd6;
    wait_cyc(e0 + 12); raw_emg_ns = 1'b0;
    wait_cyc(e0 + 20); ctrl_state = 3'd2;
    wait_cyc(e0 + 31);

    // Three-cycle glitch on EW must be rejected
    c = cyc;
    raw_emg_ew = 1'b1;
    expect_at(c + 8,  "glitch_a", PEW | EEW | BSY, NON);
    expect_at(c + 14, "glitch_b", PEW | EEW | BSY, NON);
    wait_cyc(c + 3); raw_emg_ew = 1'b0;
    wait_cyc(c + 16);

    // Simultaneous requests straight out of reset: NS first, then EW
    c = cyc;
    rst = 1'b1;
    expect_at(c + 1, "rst_sim", ALL, NON);
    wait_cyc(c + 2);
    rst        = 1'b0;
    raw_emg_ns = 1'b1;
    raw_emg_ew = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 7,  "sim_pend",     PNS | PEW | ENS | EEW,       PNS | PEW);
    expect_at(e0 + 8,  "sim_ns_first", ENS | EEW | PNS | PEW,       ENS | PNS | PEW);
    expect_at(e0 + 10, "sim_ns_ack",   ENS | EEW | PNS | PEW | BSY, PEW | BSY);
    expect_at(e0 + 20, "sim_ew_wait",  EEW | BSY | PEW,             PEW);
    expect_at(e0 + 21, "sim_ew_grant", ENS | EEW | PEW,             EEW | PEW);
    expect_at(e0 + 23, "sim_ew_ack",   EEW | PEW | BSY,             BSY);
    expect_at(e0 + 32, "sim_idle",     ALL,                         NON);
    wait_cyc(e0 + 9);  ctrl_state = 3'd6;
    wait_cyc(e0 + 11); ctrl_state = 3'd2;
    wait_cyc(e0 + 12); raw_emg_ns = 1'b0; raw_emg_ew = 1'b0;
    wait_cyc(e0 + 22); ctrl_state = 3'd7;
    wait_cyc(e0 + 23); ctrl_state = 3'd2;
    wait_cyc(e0 + 34);

    // EW grant never acknowledged (NS code shown meanwhile is not an ack)
    c = cyc;
    ctrl_state = 3'd0;
    raw_emg_ew = 1'b1;
    g = c + 1 + 8;
    expect_at(g - 1,  "to_pend",     PEW | EEW,             PEW);
    expect_at(g,      "to_grant",    EEW | PEW | BSY,       EEW | PEW | BSY);
    expect_at(g + 3,  "to_wrong_ack", EEW,                  EEW);
    expect_at(g + 15, "to_last",     EEW | TMO,             EEW);
    expect_at(g + 16, "to_expire",   EEW | TMO | PEW | BSY, TMO | PEW | BSY);
    expect_at(g + 17, "to_pulse1",   EEW | TMO,             NON);
    expect_at(g + 24, "to_cool_end", EEW | BSY | PEW,       PEW);
    expect_at(g + 25, "to_regrant",  EEW | PEW,             EEW | PEW);
    expect_at(g + 27, "to_ack",      EEW | PEW | BSY,       BSY);
    expect_at(g + 36, "to_idle",     ALL,                   NON);
    wait_cyc(g + 1);  ctrl_state = 3'd6;
    wait_cyc(g + 5);  ctrl_state = 3'd0;
    wait_cyc(g + 26); ctrl_state = 3'd7;
    wait_cyc(g + 27); ctrl_state = 3'd0; raw_emg_ew = 1'b0;
    wait_cyc(g + 38);

    // EW press debounced while NS is in SERVICE
    c = cyc;
    raw_emg_ns = 1'b1;
    e0 = c + 1;
    expect_at(e0 + 8,  "svc_ns_grant", ENS,             ENS);
    expect_at(e0 + 9,  "svc_ns_ack",   ENS | PNS | BSY, BSY);
    expect_at(e0 + 16, "svc_ew_early", PEW,             NON);
    expect_at(e0 + 17, "svc_ew_pend",  PEW | EEW | BSY, PEW | BSY);
    expect_at(e0 + 29, "svc_ew_wait",  EEW | BSY | PEW, PEW);
    expect_at(e0 + 30, "svc_ew_grant", EEW | ENS,       EEW);
    expect_at(e0 + 31, "svc_ew_hold",  EEW,             EEW);
    expect_at(e0 + 32, "svc_rst",      ALL,             NON);
    wait_cyc(e0 + 8);  ctrl_state = 3'd6;
    wait_cyc(e0 + 9);  raw_emg_ns = 1'b0; raw_emg_ew = 1'b1;
    wait_cyc(e0 + 20); ctrl_state = 3'd2; raw_emg_ew = 1'b0;
    wait_cyc(e0 + 31); rst = 1'b1;
    wait_cyc(e0 + 32); rst = 1'b0;

    // Reset pulse while emg_ns is asserted
    c = cyc;
    raw_emg_ns = 1'b1;
    e0 = c + 1;
    expect_at(e0 + 10, "rg_grant", ENS | BSY, ENS | BSY);
    expect_at(e0 + 11, "rg_reset", ALL,       NON);
    expect_at(e0 + 24, "rg_quiet", ALL,       NON);
    wait_cyc(e0 + 8);  raw_emg_ns = 1'b0;
    wait_cyc(e0 + 10); rst = 1'b1;
    wait_cyc(e0 + 11); rst = 1'b0;
    wait_cyc(e0 + 26);

    check_vec("sb_drain", 6'(sb_q.size()), 6'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
